// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out receiver: collects WIDTH serial bits LSB- or MSB-first,
// rebuilds the word and holds it in a one-entry valid/ready buffer with a sticky
// overrun flag for words that complete while the buffer is still occupied.
module shift_reg_sipo_rx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_lat_q, dir_lat_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             last_bit;
    logic             rd_fire;
    logic             dir_eff;
    logic [WIDTH-1:0] sr_shift;

    // Per-cycle qualifiers shared by the next-state and datapath logic
    assign accept   = ser_valid & ~clear;
    assign last_bit = accept & (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign rd_fire  = par_valid_q & par_ready;
    assign dir_eff  = (state_q == IDLE) ? dir : dir_lat_q;
    assign sr_shift = dir_eff ? {sr_q[WIDTH-2:0], ser_in} : {ser_in, sr_q[WIDTH-1:1]};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            dir_lat_q   <= 1'b0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            dir_lat_q   <= dir_lat_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next state: clear or the final bit of a word returns to IDLE
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = last_bit ? IDLE : SHIFT;
        end
    end

    // Datapath: shift, count, complete into the output buffer, detect overrun
    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        dir_lat_d   = dir_lat_q;
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;

        // A read empties the buffer unless a new word lands in the same cycle
        if (rd_fire) begin
            par_valid_d = 1'b0;
        end

        if (clear) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            sr_d      = sr_shift;
            dir_lat_d = dir_eff;
            if (last_bit) begin
                bit_cnt_d = '0;
                if (!par_valid_q || rd_fire) begin
                    par_out_d   = sr_shift;
                    par_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign overrun   = overrun_q;
    assign bit_cnt   = bit_cnt_q;
    assign busy      = (bit_cnt_q != '0);

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Self-checking bench for shift_reg_sipo_rx: directed scenarios plus random
// traffic against a word-level reference model; a monitor checks every word
// handed over on the parallel side against a scoreboard queue.
module tb_shift_reg_sipo_rx;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             ser_in;
    logic             ser_valid;
    logic             dir;
    logic             clear;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state (word-level view of the receiver)
    int               m_bits[$];
    logic             m_dir;
    logic             m_valid;
    logic             m_ovr;
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] exp_q[$];

    shift_reg_sipo_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .dir       (dir),
        .clear     (clear),
        .par_out   (par_out),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .overrun   (overrun),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        exp_q.delete();
        m_dir   = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_out   = '0;
    endtask

    // Assemble a word from its bits in arrival order
    function automatic logic [WIDTH-1:0] build_word(input int bits[$], input logic msb_first);
        int w = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (msb_first) w += bits[i] * (1 << (WIDTH - 1 - i));
            else           w += bits[i] * (1 << i);
        end
        return WIDTH'(w);
    endfunction

    // Predict the effect of one cycle of inputs
    task automatic model_step(input logic sv, input logic si, input logic d,
                              input logic clr, input logic rdy);
        logic             reading;
        logic             done;
        logic [WIDTH-1:0] word;
        reading = m_valid && rdy;
        done    = 1'b0;
        word    = '0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (sv) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(int'(si));
            if (m_bits.size() == WIDTH) begin
                word = build_word(m_bits, m_dir);
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (reading) m_valid = 1'b0;
        if (done) begin
            if (!m_valid) begin
                exp_q.push_back(word);
                m_out   = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic check_state();
        chk("bit_cnt",   int'(bit_cnt),   m_bits.size());
        chk("busy",      int'(busy),      int'(m_bits.size() != 0));
        chk("par_valid", int'(par_valid), int'(m_valid));
        chk("overrun",   int'(overrun),   int'(m_ovr));
        chk("par_out",   int'(par_out),   int'(m_out));
    endtask

    // Drive one cycle, advance the model, then check state after the edge
    task automatic cyc(input logic sv, input logic si, input logic d,
                       input logic clr, input logic rdy);
        ser_valid = sv;
        ser_in    = si;
        dir       = d;
        clear     = clr;
        par_ready = rdy;
        model_step(sv, si, d, clr, rdy);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic send4(input logic [3:0] bits, input logic d, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, bits[i], d, 1'b0, (i == 0) ? rdy_last : 1'b0);
        end
    endtask

    // Monitor: every handshake must hand over the oldest expected word
    always @(negedge clk) begin
        if (rst_n && par_valid && par_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake: got word 0x%0h expected no word pending", par_out);
            end else begin
                logic [WIDTH-1:0] w;
                w = exp_q.pop_front();
                if (par_out !== w) begin
                    errors++;
                    $display("FAIL handshake: got word 0x%0h expected 0x%0h", par_out, w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        dir       = 1'b0;
        clear     = 1'b0;
        par_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state();

        // Idle cycles: nothing moves
        for (int i = 0; i < 10; i++) cyc(1'b0, i[0], 1'b0, 1'b0, 1'b0);

        // LSB-first word 1,0,1,1 -> 0xD, then read it
        send4(4'b1011, 1'b0, 1'b0);
        chk("lsb_word", int'(par_out), 'hD);
        chk("lsb_valid", int'(par_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lsb_read_valid", int'(par_valid), 0);
        chk("lsb_hold", int'(par_out), 'hD);

        // MSB-first with dir toggled mid-word -> 0xB
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("msb_word", int'(par_out), 'hB);

        // Overrun: second word dropped while 0xB pending
        send4(4'b1111, 1'b1, 1'b0);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_hold", int'(par_out), 'hB);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_keeps_valid", int'(par_valid), 1);

        // Read and completion in the same cycle
        send4(4'b0110, 1'b1, 1'b1);
        chk("simul_word", int'(par_out), 'h6);
        chk("simul_valid", int'(par_valid), 1);
        chk("simul_ovr", int'(overrun), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort by clear mid-word; the clear-cycle bit is dropped
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_cnt", int'(bit_cnt), 0);
        send4(4'b0011, 1'b1, 1'b0);
        chk("clr_next_word", int'(par_out), 'h3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort by asynchronous reset mid-cycle
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ser_valid = 1'b0;
        par_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("rst_par_out", int'(par_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send4(4'b0011, 1'b1, 1'b0);
        chk("rst_next_word", int'(par_out), 'h3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 9) < 7),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 59) == 0),
                logic'($urandom_range(0, 9) < 4));
        end

        // Drain any pending word
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_sipo_rx.md
Name: shift_reg_sipo_rx

Overview:
Serial-in/parallel-out receiver. It is the far end of the universal shift register with parallel load, which sends a word serially through its shift-right or shift-left select modes. It collects WIDTH serial bits in the chosen direction and rebuilds the word. The word is then presented on a one-entry valid/ready output buffer, with overrun detection.

Parameters:
WIDTH, 4, number of bits per received word (WIDTH >= 2).
CNT_W, 3, width of bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
ser_in  input  1  serial data bit.
ser_valid  input  1  ser_in is valid this cycle; always accepted (no backpressure on the serial side).
dir  input  1  0 = LSB-first (matches transmitter shift-right); 1 = MSB-first (matches transmitter shift-left).
clear  input  1  synchronous flush of the partial word and the overrun flag.
par_out  output  WIDTH  assembled word from the output buffer.
par_valid  output  1  par_out holds an unread word.
par_ready  input  1  consumer accepts par_out when par_valid & par_ready.
overrun  output  1  sticky; a completed word was dropped.
busy  output  1  partial word in progress (bit count != 0).
bit_cnt  output  CNT_W  number of bits accepted in the current word.

Behaviour:
- Reset (rst_n=0, asynchronous): shift reg = 0, bit_cnt = 0, dir_lat = 0, par_out = 0, par_valid = 0, overrun = 0, busy = 0. State = IDLE. A reset mid-word discards the partial word.
- States:
  - IDLE (bit_cnt = 0).
  - SHIFT (0 < bit_cnt < WIDTH).
  - No separate DONE state: completion is handled in the cycle the WIDTH-th bit is accepted.
- Direction latch: dir is sampled into dir_lat on the first accepted bit of each word (IDLE & ser_valid). dir changes mid-word are ignored until the next word.
- Shifting, on each accepted bit:
  - dir_lat = 0: sr <= {ser_in, sr[WIDTH-1:1]}. After WIDTH bits the first bit sits in bit 0.
  - dir_lat = 1: sr <= {sr[WIDTH-2:0], ser_in}. After WIDTH bits the first bit sits in bit WIDTH-1.
- Counting: bit_cnt increments per accepted bit. When the accepted bit is the WIDTH-th, bit_cnt returns to 0 and state returns to IDLE. No idle cycle is required between words.
- Completion: the completed word is the shift result including the current bit.
  - If the buffer is empty, or is being read this cycle (par_valid & par_ready): par_out <= word, par_valid <= 1.
  - Otherwise the word is discarded, overrun <= 1, and par_out is unchanged.
- Latency: par_valid rises on the clock edge that accepts the WIDTH-th bit, i.e. it is visible the cycle after that bit is presented.
- Read: par_valid & par_ready with no completion in the same cycle -> par_valid <= 0. par_out holds its last value (not cleared).
- Read and completion in the same cycle: the new word loads, par_valid stays 1, no overrun.
- clear:
  - Takes priority over ser_valid. Resets sr, bit_cnt and overrun to 0 and returns state to IDLE.
  - A ser_valid bit in the same cycle is dropped.
  - Does not touch par_out or par_valid; a pending word survives.
- busy = (bit_cnt != 0), combinational from the register.
- ser_in is ignored when ser_valid = 0; no state changes.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> all outputs 0; 10 idle cycles with ser_valid=0 -> no change.
- LSB-first: dir=0, par_ready=0, bits 1,0,1,1 on consecutive cycles -> after the 4th edge par_out=4'hD, par_valid=1, busy=0, bit_cnt=0. Then par_ready=1 for one cycle -> par_valid=0, par_out stays 4'hD.
- MSB-first: dir=1, bits 1,0,1,1 -> par_out=4'hB. Toggle dir to 0 after the 2nd bit -> result still 4'hB.
- Overrun: par_ready=0. Send word 4'hB (dir=1), then word 1,1,1,1 -> overrun=1, par_out stays 4'hB. Pulse clear -> overrun=0, par_valid=1 still.
- Simultaneous read/complete: par_valid=1 with 4'hB pending; assert par_ready in the same cycle as the 4th bit of word 0,1,1,0 (dir=1) -> par_out=4'h6, par_valid=1, overrun=0.
- Mid-word abort: after 2 bits, (a) pulse clear with ser_valid=1 and ser_in=1 -> bit_cnt=0, that bit dropped; (b) repeat using async rst_n low mid-cycle -> outputs 0 immediately. In both cases the next 4 bits 0,0,1,1 (dir=1) give par_out=4'h3.
